// File: rtl/phy_pkg.sv
// Symbols and receive-FSM state type shared by the PHY serializer and deserializer.
package phy_pkg;

  localparam logic [7:0] PHY_COM  = 8'hBC;
  localparam logic [7:0] PHY_IDLE = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/phy_rx_deserializer.sv
// Serial-to-parallel PHY receiver: hunts COM alignment, then emits one byte per 8 clk_32f edges.
// Latency: byte strobed on the edge that samples its LSB; no backpressure, output is a free-running strobe.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter logic [7:0] COM       = PHY_COM,
  parameter logic [7:0] IDLE      = PHY_IDLE,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_from_tx,
  output logic [7:0] data_out,
  output logic       byte_strobe,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  rx_state_t  state_q, state_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       strobe_q, strobe_d;
  logic       valid_q, valid_d;

  logic [7:0] next_byte;
  logic       boundary;
  logic       is_com;

  assign next_byte = {sr_q[6:0], in_from_tx};
  assign boundary  = (bit_cnt_q == 3'd7);
  assign is_com    = (next_byte == COM);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    valid_d   = valid_q;

    case (state_q)
      SEARCH: begin
        // Sliding match: a COM here re-anchors the byte grid to this edge.
        if (is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = (COM_TARGET == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q + 4'd1 == COM_TARGET) begin
              state_d = ACTIVE;
            end
          end else begin
            com_cnt_d = 4'd0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          data_d   = next_byte;
          strobe_d = 1'b1;
          valid_d  = !is_com && (next_byte != IDLE);
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= next_byte;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      valid_q   <= valid_d;
    end
  end

  assign data_out    = data_q;
  assign byte_strobe = strobe_q;
  assign valid_out   = valid_q;
  assign active      = (state_q == ACTIVE);

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer: alignment, byte recovery, control symbols, async reset.
module tb_phy_rx_deserializer;

  logic       clk_32f;
  logic       reset;
  logic       in_from_tx;
  logic [7:0] data_out;
  logic       byte_strobe;
  logic       valid_out;
  logic       active;

  int errors = 0;
  int checks = 0;

  // Observations gathered while sending one byte.
  int   early_strobes;
  logic active_pre_lsb;
  logic last_strobe;

  phy_rx_deserializer #(
    .COM(8'hBC),
    .IDLE(8'h7C),
    .COM_COUNT(4)
  ) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .in_from_tx(in_from_tx),
    .data_out(data_out),
    .byte_strobe(byte_strobe),
    .valid_out(valid_out),
    .active(active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic send_bit(input logic b);
    in_from_tx = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    early_strobes = 0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      if (byte_strobe) early_strobes++;
    end
    active_pre_lsb = active;
    send_bit(b[0]);
    last_strobe = byte_strobe;
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic bring_up();
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL bring_up_active: got %b want 1", active);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] exp_data, input logic exp_valid);
    checks++;
    if (early_strobes !== 0 || last_strobe !== 1'b1) begin
      errors++;
      $display("FAIL %s_strobe: early=%0d last=%b want early=0 last=1", name, early_strobes, last_strobe);
    end
    checks++;
    if (data_out !== exp_data) begin
      errors++;
      $display("FAIL %s_data: got %h want %h", name, data_out, exp_data);
    end
    checks++;
    if (valid_out !== exp_valid) begin
      errors++;
      $display("FAIL %s_valid: got %b want %b", name, valid_out, exp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_from_tx = 1'b0;
    #2;
    checks++;
    if (data_out !== 8'h00 || byte_strobe !== 1'b0 || valid_out !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h strobe=%b valid=%b active=%b want 00 0 0 0",
               data_out, byte_strobe, valid_out, active);
    end
    do_reset();
  endtask

  task automatic test_align();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hBC);
      checks++;
      if (active !== 1'b0 || early_strobes != 0 || last_strobe !== 1'b0) begin
        errors++;
        $display("FAIL align_com%0d: active=%b strobes=%0d/%b want 0 0/0", i, active, early_strobes, last_strobe);
      end
    end
    send_byte(8'hBC);
    checks++;
    if (active_pre_lsb !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL align_rise_edge: pre=%b post=%b want 0 1", active_pre_lsb, active);
    end
    checks++;
    if (last_strobe !== 1'b0 || early_strobes != 0) begin
      errors++;
      $display("FAIL align_com_not_strobed: early=%0d last=%b want 0 0", early_strobes, last_strobe);
    end
  endtask

  task automatic test_data();
    logic [7:0] bytes [4];
    bytes[0] = 8'hCC; bytes[1] = 8'hFD; bytes[2] = 8'hAA; bytes[3] = 8'h12;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      check_byte($sformatf("data%0d", i), bytes[i], 1'b1);
    end
  endtask

  task automatic test_ctrl_symbols();
    bring_up();
    send_byte(8'h7C);
    check_byte("idle", 8'h7C, 1'b0);
    send_byte(8'hBC);
    check_byte("com", 8'hBC, 1'b0);
    send_bit(1'b0);
    checks++;
    if (valid_out !== 1'b0 || byte_strobe !== 1'b0 || data_out !== 8'hBC) begin
      errors++;
      $display("FAIL ctrl_hold: valid=%b strobe=%b data=%h want 0 0 bc", valid_out, byte_strobe, data_out);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_active: got %b want 1", active);
    end
    send_byte(8'hCA);
    check_byte("misaligned", 8'hCA, 1'b1);
  endtask

  task automatic test_abort();
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h7C);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL abort_after_idle: active=%b want 0", active);
    end
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL abort_three_com: active=%b want 0", active);
    end
    send_byte(8'hBC);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL abort_reactivate: active=%b want 1", active);
    end
    send_byte(8'h3C);
    check_byte("abort_data", 8'h3C, 1'b1);
  endtask

  task automatic test_mid_reset();
    bring_up();
    send_byte(8'hA5);
    check_byte("pre_reset", 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0 || byte_strobe !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: data=%h valid=%b active=%b strobe=%b want 00 0 0 0",
               data_out, valid_out, active, byte_strobe);
    end
    @(negedge clk_32f);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_three_com: active=%b want 0", active);
    end
    send_byte(8'hBC);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_reactivate: active=%b want 1", active);
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_data();
    test_ctrl_symbols();
    test_misaligned();
    test_abort();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phy_rx_deserializer.md
# phy_rx_deserializer

Serial-to-parallel receive front end of the PHY, the counterpart to the transmit serializer on the same link. It samples one bit per `clk_32f` cycle from the transmitter's serial line and finds byte alignment by hunting for COM symbols. After a run of consecutive COMs it declares the link active. From then on it delivers one byte per 8 cycles with a data-valid qualifier, feeding the receive-side lane unstriper.

## Interface
Parameters:
- `COM`, 8'hBC, alignment/comma symbol
- `IDLE`, 8'h7C, idle filler symbol
- `COM_COUNT`, 4, consecutive aligned COMs required to go active (legal range 1..15)

Ports:
- `clk_32f`  in  1  bit clock; one clock domain, all logic on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `in_from_tx`  in  1  serial line, MSB of each byte first
- `data_out`  out  8  last completed byte; holds between strobes
- `byte_strobe`  out  1  one-cycle pulse when `data_out` updates (ACTIVE only)
- `valid_out`  out  1  qualifies `data_out`; meaningful with `byte_strobe`
- `active`  out  1  high while in ACTIVE

## Operation
- Shift register `sr[7:0]`; every edge: `sr <= {sr[6:0], in_from_tx}`. Let `next = {sr[6:0], in_from_tx}`.
- Bit counter `bit_cnt[2:0]`, wraps 7→0. A byte boundary is an edge with `bit_cnt == 7`.
- COM counter `com_cnt[3:0]`.
- States: SEARCH, ALIGN, ACTIVE.
  - SEARCH: sliding compare every edge. If `next == COM`:
    - `bit_cnt <= 0`, `com_cnt <= 1`.
    - Go to ALIGN, or straight to ACTIVE if `COM_COUNT == 1`.
  - ALIGN: compare only at byte boundaries.
    - `next == COM`: `com_cnt++`; on reaching `COM_COUNT`, go to ACTIVE.
    - Any other byte, including IDLE: `com_cnt <= 0`, back to SEARCH.
  - ACTIVE: at every byte boundary:
    - `data_out <= next`, `byte_strobe <= 1`.
    - `valid_out <= (next != COM) && (next != IDLE)`.
    - Stays ACTIVE until `reset`; no loss-of-lock detection in this block.
- `byte_strobe` is 0 on all non-boundary edges. `valid_out` holds its last value.
- Reset values: `sr = 0`, `bit_cnt = 0`, `com_cnt = 0`, state SEARCH, `data_out = 8'h00`, `byte_strobe = 0`, `valid_out = 0`, `active = 0`.
- Reset value `sr = 0` cannot produce a spurious COM match.

## Timing
- Bit sampled on each rising edge of `clk_32f`.
- Byte output latency is zero edges after the last bit: `data_out`, `byte_strobe` and `valid_out` update on the same edge that samples bit 0 (LSB) of the byte.
- `active` rises on the edge that samples the LSB of the `COM_COUNT`-th consecutive COM. That COM itself is not strobed out.
- First strobe comes 8 edges after `active` rises.
- Strobe period in ACTIVE is exactly 8 edges, with no gaps.
- Reset asserted mid-byte or mid-ALIGN:
  - All outputs go to reset values asynchronously, without waiting for a clock edge.
  - After release, realignment restarts from SEARCH.
- A non-COM byte arriving in ALIGN on the same edge that would otherwise complete the count: the mismatch wins, go to SEARCH.

## Structure
- Shared package `phy_pkg`:
  - `COM`/`IDLE` symbol constants, also used by the TX serializer.
  - State enum `rx_state_t` {SEARCH, ALIGN, ACTIVE}.
- Single module, no sub-modules. The comparator and counters are small enough to inline.

## Test plan
- Reset, then 4×8'hBC MSB-first → `active` rises on the LSB edge of the 4th BC; no strobes before it.
- Active, then send 8'hCC, 8'hFD, 8'hAA, 8'h12 → four strobes 8 edges apart, `valid_out = 1`, `data_out` matches each byte in order.
- Active, then send 8'h7C and 8'hBC → strobes with `valid_out = 0`, `data_out` = 8'h7C then 8'hBC.
- 3 random bits, then 4×BC (misaligned start) → alignment found; the next byte 8'hCA is recovered exactly.
- BC, BC, 8'h7C, then 4×BC → returns to SEARCH after the 7C; `active` only after the final 4 BCs.
- `reset` pulsed mid-byte while ACTIVE → outputs clear at once with no clock edge; 4 BCs are needed to reactivate.
